apu_envelope_bank: RTL and testbench
====================================

Name: apu_envelope_bank

Overview:
N-channel envelope generator bank for the APU. Replaces the per-voice single envelope instances feeding pulse 1, pulse 2 and noise. All channels share one quarter-frame tick. Each channel has:
- its own parameter register (loop, constant-volume and period/volume fields)
- a start flag, a divider and a decay counter

Compared with the single-channel unit, this block adds a correct divider reload on restart and on divider expiry, a configurable field width and channel count, a per-channel loop flag for length-counter halt, and a debug readback port.

Parameters:
NUM_CH, 3, number of envelope channels (must be 1..16).
PARAM_W, 4, width of the period/constant-volume field. This is also the volume output width. Decay maximum is 2^PARAM_W-1.
CH_W, 2, width of channel-select ports. Must satisfy 2^CH_W >= NUM_CH.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
qframe_en  in  1  quarter-frame tick, one clk wide
wr_en  in  1  parameter register write strobe
wr_ch  in  CH_W  channel written by wr_en
wr_data  in  PARAM_W+2  bit PARAM_W+1 = loop/halt, bit PARAM_W = constant-volume, bits PARAM_W-1:0 = period/volume
restart  in  NUM_CH  per-channel restart strobes (side effect of a length/timer-high write)
vol_out  out  NUM_CH*PARAM_W  channel c volume at bits [c*PARAM_W +: PARAM_W]
loop_out  out  NUM_CH  per-channel loop flag, driven to the length counter halt input
rd_ch  in  CH_W  debug readback channel select
rd_decay  out  PARAM_W  decay counter of rd_ch; combinational; 0 when rd_ch >= NUM_CH

Behaviour:
- Reset (rst=1 at a clk edge), every channel: param=0, start=0, divider=0, decay=0. Resulting outputs: vol_out=0, loop_out=0, rd_decay=0. Reset overrides every other input in the same cycle.
- Write: when wr_en=1 and wr_ch<NUM_CH, param[wr_ch] <= wr_data. When wr_ch>=NUM_CH the write is ignored. A write never touches start, divider or decay.
- Restart: restart[c]=1 sets start[c]. Multiple bits may be set in one cycle.
- Quarter-frame, evaluated per channel only in cycles with qframe_en=1, in priority order:
  1. If start=1: start<=0, decay<=all-ones, divider<=period.
  2. Else if divider==0: divider<=period. Then if decay!=0, decay<=decay-1; else if loop=1, decay<=all-ones; else decay holds 0.
  3. Else: divider<=divider-1.
- Divider period is period+1 quarter-frames. period=0 clocks decay on every tick.
- Simultaneous events in one cycle:
  - qframe_en with restart[c]: the quarter-frame action uses the old start value. start[c] ends at 1, so restart takes effect on the next tick.
  - qframe_en with a write to the same channel: the quarter-frame action uses the old param. The new param applies from the next cycle.
  - wr_en with restart for the same channel: both happen.
- Output, combinational from registers: vol_out[c] = const ? period : decay. loop_out[c] = param[c] loop bit. Latency from a param write to the output is 1 clk. Latency from a tick to the new decay on the output is 1 clk.
- Arithmetic: all counters are unsigned PARAM_W bits. There is no wrap below 0; the divider==0 branch prevents it.
- Mid-operation reset: rst clears pending start flags and in-progress decays. A tick in the same cycle is discarded.

Decomposition:
- Shared APU package: field positions of wr_data (LOOP_BIT, CONST_BIT), a DECAY_MAX function of PARAM_W, and channel index constants CH_PULSE1=0, CH_PULSE2=1, CH_NOISE=2.
- One sub-module, apu_env_channel. It holds a single channel's param, start, divider and decay, with ports for tick, wr, restart, vol, loop and decay.
- The bank instantiates NUM_CH copies via generate. It adds the write-select decode, output packing and the readback mux.

Test Plan:
- Reset then no stimulus: vol_out=0, loop_out=0 and rd_decay=0 on all channels for 20 ticks.
- Ch0 write loop=0, const=0, period=2. Restart, then 1 tick: decay=15. Further ticks: decay decrements every 3rd tick (15,14 after 3 ticks, ...). decay reaches 0 after 45 more ticks and stays 0.
- Ch1 write loop=1, period=0, then restart. decay=15 after the first tick, then 14..0 one per tick, then 15 on the next tick; loop_out[1]=1.
- Ch2 write const=1, period=9: vol_out[2]=9 one cycle after the write, regardless of ticks. decay still runs; rd_ch=2 shows it counting.
- Restart asserted in the same cycle as qframe_en, with decay=5 and divider=0: this tick gives decay=4. The next tick gives decay=15 and divider=period.
- Write with wr_ch=3 (NUM_CH=3): no channel changes. Write to ch0 coincident with a tick: the tick uses the old period, and the new period is loaded at the next divider reload.

Source files
------------

// File: rtl/apu_envelope_bank_pkg.sv
// Shared APU envelope definitions: wr_data field positions, the decay
// reload value and the fixed channel assignment of the APU voices.
package apu_envelope_bank_pkg;

  // Voice-to-channel mapping used by the APU top level.
  localparam int CH_PULSE1 = 0;
  localparam int CH_PULSE2 = 1;
  localparam int CH_NOISE  = 2;

  // Position of the loop/length-halt bit within wr_data.
  function automatic int loop_bit(input int param_w);
    return param_w + 1;
  endfunction

  // Position of the constant-volume bit within wr_data.
  function automatic int const_bit(input int param_w);
    return param_w;
  endfunction

  // Value the decay counter reloads to (all ones for the field width).
  function automatic int decay_max(input int param_w);
    return (1 << param_w) - 1;
  endfunction

endpackage

// File: rtl/apu_env_channel.sv
// One envelope channel: parameter register, start flag, divider and
// decay counter, advanced by the shared quarter-frame tick.
module apu_env_channel
  import apu_envelope_bank_pkg::*;
#(
  parameter int PARAM_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               wr_en,
  input  logic [PARAM_W+1:0] wr_data,
  input  logic               restart,
  output logic [PARAM_W-1:0] vol,
  output logic               loop,
  output logic [PARAM_W-1:0] decay
);

  localparam int LOOP_B  = loop_bit(PARAM_W);
  localparam int CONST_B = const_bit(PARAM_W);
  localparam logic [PARAM_W-1:0] DECAY_FULL = PARAM_W'(decay_max(PARAM_W));
  localparam logic [PARAM_W-1:0] ONE        = PARAM_W'(1);

  logic [PARAM_W+1:0] param;
  logic               start;
  logic [PARAM_W-1:0] divider;
  logic [PARAM_W-1:0] decay_cnt;
  logic [PARAM_W-1:0] period;

  assign period = param[PARAM_W-1:0];

  // Parameter write, start flag and divider/decay sequencing. The tick
  // branch reads the pre-edge param and start, so a coincident write or
  // restart only becomes visible to the next tick. The restart set is
  // placed after the tick's clear so a coincident restart leaves start=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      param     <= '0;
      start     <= 1'b0;
      divider   <= '0;
      decay_cnt <= '0;
    end else begin
      if (wr_en) begin
        param <= wr_data;
      end
      if (tick) begin
        if (start) begin
          start     <= 1'b0;
          decay_cnt <= DECAY_FULL;
          divider   <= period;
        end else if (divider == '0) begin
          divider <= period;
          if (decay_cnt != '0) begin
            decay_cnt <= decay_cnt - ONE;
          end else if (param[LOOP_B]) begin
            decay_cnt <= DECAY_FULL;
          end
        end else begin
          divider <= divider - ONE;
        end
      end
      if (restart) begin
        start <= 1'b1;
      end
    end
  end

  // Outputs are purely combinational from the channel registers.
  assign vol   = param[CONST_B] ? period : decay_cnt;
  assign loop  = param[LOOP_B];
  assign decay = decay_cnt;

endmodule

// File: rtl/apu_envelope_bank.sv
// Envelope generator bank: NUM_CH independent envelope channels sharing
// one quarter-frame tick, with a channel-addressed parameter write port,
// packed volume/loop outputs and a debug readback of the decay counters.
// NUM_CH must be 1..16 and 2^CH_W must cover NUM_CH.
module apu_envelope_bank
  import apu_envelope_bank_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int PARAM_W = 4,
  parameter int CH_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      qframe_en,
  input  logic                      wr_en,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [PARAM_W+1:0]        wr_data,
  input  logic [NUM_CH-1:0]         restart,
  output logic [NUM_CH*PARAM_W-1:0] vol_out,
  output logic [NUM_CH-1:0]         loop_out,
  input  logic [CH_W-1:0]           rd_ch,
  output logic [PARAM_W-1:0]        rd_decay
);

  logic [NUM_CH-1:0]  wr_sel;
  logic [PARAM_W-1:0] decay_arr [NUM_CH];

  // Write-select decode: a channel number with no matching channel
  // selects nothing, so out-of-range writes are dropped.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_sel[c] = wr_en && (wr_ch == CH_W'(c));

    apu_env_channel #(
      .PARAM_W (PARAM_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (qframe_en),
      .wr_en   (wr_sel[c]),
      .wr_data (wr_data),
      .restart (restart[c]),
      .vol     (vol_out[c*PARAM_W +: PARAM_W]),
      .loop    (loop_out[c]),
      .decay   (decay_arr[c])
    );
  end

  // Debug readback mux; unpopulated channel numbers read as zero.
  always_comb begin
    rd_decay = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) begin
        rd_decay = decay_arr[c];
      end
    end
  end

endmodule

// File: tb/tb_apu_envelope_bank.sv
// Scoreboard bench for apu_envelope_bank: directed sequences plus random
// traffic, checked against a per-channel behavioural envelope model.
module tb_apu_envelope_bank;

  localparam int NUM_CH  = 3;
  localparam int PARAM_W = 4;
  localparam int CH_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      qframe_en = 1'b0;
  logic                      wr_en = 1'b0;
  logic [CH_W-1:0]           wr_ch = '0;
  logic [PARAM_W+1:0]        wr_data = '0;
  logic [NUM_CH-1:0]         restart = '0;
  logic [NUM_CH*PARAM_W-1:0] vol_out;
  logic [NUM_CH-1:0]         loop_out;
  logic [CH_W-1:0]           rd_ch = '0;
  logic [PARAM_W-1:0]        rd_decay;

  apu_envelope_bank #(
    .NUM_CH  (NUM_CH),
    .PARAM_W (PARAM_W),
    .CH_W    (CH_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .qframe_en (qframe_en),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_data   (wr_data),
    .restart   (restart),
    .vol_out   (vol_out),
    .loop_out  (loop_out),
    .rd_ch     (rd_ch),
    .rd_decay  (rd_decay)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH*PARAM_W-1:0] vol;
    logic [NUM_CH-1:0]         loop;
    logic [PARAM_W-1:0]        rd;
    int                        pin;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: plain integers per channel.
  int m_loop[NUM_CH], m_const[NUM_CH], m_period[NUM_CH];
  int m_start[NUM_CH], m_div[NUM_CH], m_dec[NUM_CH];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Apply one clock of stimulus; the model advances for the edge that
  // will sample it and the expected post-edge outputs are queued.
  task automatic step(input logic r, input logic q, input logic we,
                      input logic [CH_W-1:0] wc, input logic [PARAM_W+1:0] wd,
                      input logic [NUM_CH-1:0] rs, input logic [CH_W-1:0] rc,
                      input int pin);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; qframe_en = q; wr_en = we; wr_ch = wc; wr_data = wd;
    restart = rs; rd_ch = rc;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r) begin
        m_loop[c] = 0; m_const[c] = 0; m_period[c] = 0;
        m_start[c] = 0; m_div[c] = 0; m_dec[c] = 0;
      end else begin
        if (q) begin
          if (m_start[c] != 0) begin
            m_start[c] = 0;
            m_dec[c]   = 15;
            m_div[c]   = m_period[c];
          end else if (m_div[c] == 0) begin
            m_div[c] = m_period[c];
            if (m_dec[c] > 0) m_dec[c] = m_dec[c] - 1;
            else if (m_loop[c] != 0) m_dec[c] = 15;
          end else begin
            m_div[c] = m_div[c] - 1;
          end
        end
        if (rs[c]) m_start[c] = 1;
        if (we && int'(wc) == c) begin
          m_loop[c]   = int'(wd[5]);
          m_const[c]  = int'(wd[4]);
          m_period[c] = int'(wd[3:0]);
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      e.vol[c*PARAM_W +: PARAM_W] = 4'((m_const[c] != 0) ? m_period[c] : m_dec[c]);
      e.loop[c] = (m_loop[c] != 0);
    end
    e.rd  = (int'(rc) < NUM_CH) ? 4'(m_dec[int'(rc)]) : 4'd0;
    e.pin = pin;
    sb.push_back(e);
  endtask

  task automatic tk(input logic [CH_W-1:0] rc, input int pin);
    step(1'b0, 1'b1, 1'b0, '0, '0, '0, rc, pin);
  endtask

  task automatic wr(input logic [CH_W-1:0] wc, input logic [PARAM_W+1:0] wd);
    step(1'b0, 1'b0, 1'b1, wc, wd, '0, wc, -1);
  endtask

  task automatic rs_only(input logic [NUM_CH-1:0] rs, input logic [CH_W-1:0] rc);
    step(1'b0, 1'b0, 1'b0, '0, '0, rs, rc, -1);
  endtask

  // Monitor: outputs settle one unit after each edge, before the driver
  // changes inputs, and are compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("vol_out", int'(vol_out), int'(e.vol));
        check("loop_out", int'(loop_out), int'(e.loop));
        check("rd_decay", int'(rd_decay), int'(e.rd));
        if (e.pin >= 0) check("rd_decay_plan", int'(rd_decay), e.pin);
      end
    end
  end

  initial begin
    // Reset, then idle ticks: everything stays zero.
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, 2'd0, 0);
    step(1'b1, 1'b1, 1'b0, '0, '0, '1, 2'd1, 0);
    for (int i = 0; i < 20; i++) tk(2'(i % 4), 0);

    // Ch0: no loop, period 2 -> one decay step every third tick.
    wr(2'd0, 6'h02);
    rs_only(3'b001, 2'd0);
    tk(2'd0, 15);
    for (int i = 1; i <= 45; i++) tk(2'd0, 15 - i / 3);
    for (int i = 0; i < 3; i++) tk(2'd0, 0);

    // Ch1: loop, period 0 -> decays every tick and wraps to 15.
    wr(2'd1, 6'h20);
    rs_only(3'b010, 2'd1);
    tk(2'd1, 15);
    for (int i = 1; i <= 15; i++) tk(2'd1, 15 - i);
    tk(2'd1, 15);
    for (int i = 1; i <= 10; i++) tk(2'd1, 15 - i);
    // Restart coincident with a tick at decay=5, divider=0.
    step(1'b0, 1'b1, 1'b0, '0, '0, 3'b010, 2'd1, 4);
    tk(2'd1, 15);

    // Ch2: constant volume 9; decay still runs underneath.
    wr(2'd2, 6'h19);
    rs_only(3'b100, 2'd2);
    tk(2'd2, 15);
    for (int i = 1; i <= 9; i++) tk(2'd2, 15);
    tk(2'd2, 14);

    // Write to channel 3 (does not exist) is dropped.
    wr(2'd3, 6'h3f);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'd3, 0);

    // Ch0 write coincident with a divider reload tick.
    rs_only(3'b001, 2'd0);
    tk(2'd0, 15);
    tk(2'd0, 15);
    tk(2'd0, 15);
    step(1'b0, 1'b1, 1'b1, 2'd0, 6'h05, '0, 2'd0, 14);
    tk(2'd0, 14);
    tk(2'd0, 14);
    tk(2'd0, 13);
    for (int i = 0; i < 5; i++) tk(2'd0, 13);
    tk(2'd0, 12);

    // Random traffic, including rare mid-run resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)),
           6'($urandom),
           ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0,
           2'($urandom_range(0, 3)),
           -1);
    end
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'd0, -1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
